// File: rtl/seq_step_if.sv
// Control/status bundle between the step-sequencer controller and its surroundings
// (command pulses and keypad in, divider enable and note/gate out).
interface seq_step_if #(
  parameter int STEPS  = 8,
  parameter int NOTE_W = 4
);
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic              play;
  logic              stop;
  logic              rec;
  logic              clear;
  logic              beat_pulse;
  logic              key_valid;
  logic [NOTE_W-1:0] key_note;

  logic              sequencer_on;
  logic [IDX_W-1:0]  step_idx;
  logic [NOTE_W-1:0] note_out;
  logic              gate;
  logic              recording;

  modport master (
    output play, stop, rec, clear, beat_pulse, key_valid, key_note,
    input  sequencer_on, step_idx, note_out, gate, recording
  );

  modport slave (
    input  play, stop, rec, clear, beat_pulse, key_valid, key_note,
    output sequencer_on, step_idx, note_out, gate, recording
  );
endinterface

// File: rtl/seq_step_controller.sv
// Play/stop/record step sequencer: walks a STEPS-entry note pattern on divider
// beats, emits a timed gate per step, and records keypad notes in REC mode.
module seq_step_controller #(
  parameter int STEPS       = 8,
  parameter int NOTE_W      = 4,
  parameter int GATE_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       n_rst,
  seq_step_if.slave  bus
);
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TMR_W = $clog2(GATE_CYCLES + 1);
  localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES);

  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_REC} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               step_q, step_d, step_nx;
  logic [NOTE_W-1:0]              note_q, note_d;
  logic [TMR_W-1:0]               timer_q, timer_d;
  logic [STEPS-1:0][NOTE_W-1:0]   pat_q, pat_d;
  logic                           seq_on_q, rec_q, gate_q;

  assign step_nx = step_q + 1'b1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    note_d  = note_q;
    timer_d = (timer_q != '0) ? timer_q - 1'b1 : '0;
    pat_d   = pat_q;
    case (state_q)
      ST_STOP: begin
        if (bus.clear) pat_d = '0;
        if (!bus.stop && (bus.play || bus.rec)) begin
          state_d = bus.play ? ST_PLAY : ST_REC;
          step_d  = '0;
          note_d  = pat_q[0];
          timer_d = GATE_LOAD;
        end
      end
      ST_PLAY, ST_REC: begin
        if (bus.stop) begin
          state_d = ST_STOP;
          step_d  = '0;
          note_d  = '0;
          timer_d = '0;
        end else begin
          if (bus.rec) state_d = (state_q == ST_REC) ? ST_PLAY : ST_REC;
          // Write lands on the pre-advance step; the beat read below sees old contents.
          if (state_q == ST_REC && bus.key_valid) begin
            pat_d[step_q] = bus.key_note;
            note_d        = bus.key_note;
            timer_d       = GATE_LOAD;
          end
          if (bus.beat_pulse) begin
            step_d  = step_nx;
            note_d  = pat_q[step_nx];
            timer_d = GATE_LOAD;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_STOP;
      step_q   <= '0;
      note_q   <= '0;
      timer_q  <= '0;
      pat_q    <= '0;
      seq_on_q <= 1'b0;
      rec_q    <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      note_q   <= note_d;
      timer_q  <= timer_d;
      pat_q    <= pat_d;
      seq_on_q <= (state_d != ST_STOP);
      rec_q    <= (state_d == ST_REC);
      gate_q   <= (timer_d != '0) && (note_d != '0);
    end
  end

  assign bus.sequencer_on = seq_on_q;
  assign bus.recording    = rec_q;
  assign bus.step_idx     = step_q;
  assign bus.note_out     = note_q;
  assign bus.gate         = gate_q;
endmodule

// File: tb/tb_seq_step_controller.sv
// Directed bench for seq_step_controller: record, playback, wrap, stop, clear,
// simultaneous commands, retrigger and asynchronous reset.
module tb_seq_step_controller;
  localparam int STEPS = 8;
  localparam int NOTE_W = 4;
  localparam int GC = 4;

  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_step = 0;
  int   exp_pat [STEPS];
  int   n;

  seq_step_if #(.STEPS(STEPS), .NOTE_W(NOTE_W)) bus ();

  seq_step_controller #(.STEPS(STEPS), .NOTE_W(NOTE_W), .GATE_CYCLES(GC)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; command pulses last exactly one sampled edge.
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      bus.play = 0; bus.stop = 0; bus.rec = 0; bus.clear = 0;
      bus.beat_pulse = 0; bus.key_valid = 0; bus.key_note = '0;
    end
  endtask

  // Count consecutive gate-high samples starting now (bounded).
  task automatic count_gate(output int cnt);
    cnt = 0;
    while (bus.gate === 1'b1 && cnt < 50) begin
      cnt++;
      cyc(1);
    end
  endtask

  task automatic beat_step(input string tag);
    int c;
    exp_step = (exp_step + 1) % STEPS;
    bus.beat_pulse = 1; cyc(1);
    chk({tag, "_step"}, bus.step_idx, exp_step);
    chk({tag, "_note"}, bus.note_out, exp_pat[exp_step]);
    count_gate(c);
    chk({tag, "_gatelen"}, c, (exp_pat[exp_step] != 0) ? GC : 0);
    cyc(10);
  endtask

  initial begin
    for (int i = 0; i < STEPS; i++) exp_pat[i] = 0;
    n_rst = 0;
    bus.play = 0; bus.stop = 0; bus.rec = 0; bus.clear = 0;
    bus.beat_pulse = 0; bus.key_valid = 0; bus.key_note = '0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1;
    cyc(1);
    chk("rst_seq_on", bus.sequencer_on, 0);
    chk("rst_rec", bus.recording, 0);
    chk("rst_gate", bus.gate, 0);
    chk("rst_step", bus.step_idx, 0);
    chk("rst_note", bus.note_out, 0);
    bus.beat_pulse = 1; cyc(1);
    chk("stop_beat_step", bus.step_idx, 0);
    chk("stop_beat_seq_on", bus.sequencer_on, 0);

    // Record 5 at step 0, 3 at step 1
    bus.rec = 1; cyc(1);
    chk("rec_seq_on", bus.sequencer_on, 1);
    chk("rec_recording", bus.recording, 1);
    chk("rec_step", bus.step_idx, 0);
    chk("rec_gate_rest", bus.gate, 0);
    bus.key_valid = 1; bus.key_note = 5; cyc(1);
    exp_pat[0] = 5;
    chk("key5_note", bus.note_out, 5);
    count_gate(n);
    chk("key5_gatelen", n, GC);
    cyc(5);
    beat_step("rec_beat1");
    bus.key_valid = 1; bus.key_note = 3; cyc(1);
    exp_pat[1] = 3;
    chk("key3_note", bus.note_out, 3);
    count_gate(n);
    chk("key3_gatelen", n, GC);

    // To PLAY, eight beats wrapping through 7 -> 0
    bus.rec = 1; cyc(1);
    chk("play_recording", bus.recording, 0);
    chk("play_seq_on", bus.sequencer_on, 1);
    chk("play_step_kept", bus.step_idx, 1);
    cyc(5);
    for (int i = 0; i < 8; i++) beat_step("play_loop");

    bus.stop = 1; cyc(1);
    exp_step = 0;
    chk("stop_step", bus.step_idx, 0);
    chk("stop_seq_on", bus.sequencer_on, 0);
    chk("stop_note", bus.note_out, 0);
    chk("stop_gate", bus.gate, 0);

    bus.play = 1; cyc(1);
    chk("replay_note", bus.note_out, 5);
    count_gate(n);
    chk("replay_gatelen", n, GC);
    cyc(5);
    beat_step("replay_b1");
    bus.play = 1; cyc(1);
    chk("play_ignored_step", bus.step_idx, 1);

    // Simultaneous key + beat in REC at step 2
    bus.rec = 1; cyc(1);
    chk("rec2_recording", bus.recording, 1);
    beat_step("rec2_b2");
    bus.key_valid = 1; bus.key_note = 9; bus.beat_pulse = 1; cyc(1);
    exp_pat[2] = 9; exp_step = 3;
    chk("simul_step", bus.step_idx, 3);
    chk("simul_note", bus.note_out, 0);
    chk("simul_gate", bus.gate, 0);

    // Retrigger with gate 2 cycles from expiry
    bus.key_valid = 1; bus.key_note = 6; cyc(1);
    exp_pat[3] = 6;
    chk("key6_gate", bus.gate, 1);
    cyc(1);
    chk("key6_gate_t3", bus.gate, 1);
    cyc(1);
    chk("key6_gate_t2", bus.gate, 1);
    bus.key_valid = 1; bus.key_note = 7; cyc(1);
    exp_pat[3] = 7;
    chk("retrig_note", bus.note_out, 7);
    count_gate(n);
    chk("retrig_gatelen", n, GC);

    // stop + play together
    bus.stop = 1; bus.play = 1; cyc(1);
    exp_step = 0;
    chk("stopplay_seq_on", bus.sequencer_on, 0);
    chk("stopplay_rec", bus.recording, 0);
    chk("stopplay_step", bus.step_idx, 0);
    bus.stop = 1; bus.play = 1; cyc(1);
    chk("stopplay_idle_seq_on", bus.sequencer_on, 0);

    // Playback confirms pattern 5,3,9,7; clear in PLAY ignored
    bus.play = 1; cyc(1);
    chk("pb_note0", bus.note_out, 5);
    count_gate(n);
    chk("pb_gatelen0", n, GC);
    cyc(5);
    for (int i = 0; i < 3; i++) beat_step("pb");
    bus.clear = 1; cyc(1);
    chk("clr_play_seq_on", bus.sequencer_on, 1);
    for (int i = 0; i < 5; i++) beat_step("pb_after_clr");

    // Clear in STOP zeroes everything
    bus.stop = 1; cyc(1);
    bus.clear = 1; cyc(1);
    for (int i = 0; i < STEPS; i++) exp_pat[i] = 0;
    exp_step = 0;
    bus.play = 1; cyc(1);
    chk("clr_note0", bus.note_out, 0);
    chk("clr_gate0", bus.gate, 0);
    cyc(5);
    beat_step("clr_pb");
    beat_step("clr_pb");

    // Async reset mid-record wipes pattern too
    bus.rec = 1; cyc(1);
    bus.key_valid = 1; bus.key_note = 4; cyc(1);
    chk("key4_gate", bus.gate, 1);
    n_rst = 0; #2;
    chk("arst_gate", bus.gate, 0);
    chk("arst_seq_on", bus.sequencer_on, 0);
    chk("arst_rec", bus.recording, 0);
    chk("arst_step", bus.step_idx, 0);
    chk("arst_note", bus.note_out, 0);
    n_rst = 1;
    cyc(2);
    exp_step = 0;
    bus.play = 1; cyc(1);
    chk("arst_pb_note0", bus.note_out, 0);
    beat_step("arst_pb");
    beat_step("arst_pb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_step_controller.md
# seq_step_controller

Step-sequencer controller sitting above the sequencer beat clock divider. Owns play/stop/record mode and drives the divider's `sequencer_on` enable. Consumes its `beat_pulse` to advance through a STEPS-entry note pattern held in an internal register array. Emits the current step's note with a timed gate to the tone generator; in record mode it writes keypad notes into the pattern.

## Interface
- STEPS, 8: pattern length; power of two, 2..16.
- NOTE_W, 4: note code width; code 0 = rest.
- GATE_CYCLES, 2500000: gate-high duration in clk cycles per triggered step; must be ≥1 and < beat period.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- play  in  1  single-cycle pulse: start playback.
- stop  in  1  single-cycle pulse: stop and rewind.
- rec  in  1  single-cycle pulse: toggle record mode.
- clear  in  1  single-cycle pulse: zero the whole pattern (honoured in STOP only).
- beat_pulse  in  1  one-cycle step tick from the clock divider.
- key_valid  in  1  keypad note strobe, one cycle.
- key_note  in  NOTE_W  note code, valid with key_valid.
- sequencer_on  out  1  enable to clock divider; high in PLAY and REC.
- step_idx  out  clog2(STEPS)  current step.
- note_out  out  NOTE_W  note of current step.
- gate  out  1  note sounding.
- recording  out  1  high in REC.

## Operation
- States: STOP (reset), PLAY, REC.
- Command priority in the same cycle: stop > play > rec.
- Transitions:
  - STOP: play → PLAY; rec → REC.
  - PLAY: rec → REC; stop → STOP.
  - REC: rec → PLAY; stop → STOP.
  - play in PLAY or REC: ignored, no restart.
- Entering PLAY or REC from STOP:
  - step_idx = 0.
  - note_out = pattern[0].
  - gate timer loads GATE_CYCLES, so step 0 sounds immediately.
- beat_pulse in PLAY or REC:
  - step_idx ← step_idx+1, wrapping STEPS−1 → 0.
  - note_out ← pattern[new step].
  - Gate timer reloads GATE_CYCLES.
- beat_pulse in STOP: ignored.
- gate = (gate timer ≠ 0) && (note_out ≠ 0). Rests never raise gate.
- Gate timer decrements once per cycle while nonzero.
- key_valid in REC:
  - pattern[step_idx] ← key_note.
  - note_out ← key_note.
  - Gate timer reloads (retrigger).
- key_valid in STOP or PLAY: ignored.
- key_valid and beat_pulse in the same REC cycle:
  - Write goes to the pre-advance step.
  - Step advance and note_out ← pattern[new step] still occur; read of the new step is unaffected by the write.
- clear in STOP: all pattern entries ← 0 in one cycle. Ignored in PLAY and REC.
- Entering STOP:
  - step_idx ← 0.
  - note_out ← 0.
  - Gate timer ← 0.
  - Pattern retained.
- Timer width: clog2(GATE_CYCLES+1) bits, unsigned; never underflows.

## Timing
- All outputs registered; every command takes effect at the clock edge where it is sampled, visible the next cycle.
- Reset values:
  - State STOP.
  - sequencer_on, recording, gate: 0.
  - step_idx 0, note_out 0.
  - Pattern all 0.
  - Gate timer 0.
- Reset is asynchronous mid-operation: all of the above apply immediately, including pattern contents.
- sequencer_on is 1 in the cycle after play/rec is sampled in STOP; 0 in the cycle after stop. The divider restarts its count from 0 on each start, so the first beat arrives one full beat period after start.
- gate rises 1 cycle after start, beat or key write (if note ≠ 0), and stays high exactly GATE_CYCLES cycles unless retriggered or stopped.
- A retrigger while gate is high extends it; gate does not drop for a cycle.

## Test plan
- Reset / idle:
  - Stimulus: assert n_rst low mid-run, release; pulse beat_pulse in STOP.
  - Required: all outputs 0, state STOP; beat_pulse causes no step change.
- Record and playback (STEPS=8, GATE_CYCLES=4, bench drives beat_pulse every 20 cycles):
  - Stimulus: rec from STOP; key 5 at step 0, key 3 at step 1 (after beat); rec to PLAY.
  - Required: note_out 5, 3, 0×6 repeating; gate high 4 cycles on steps 0 and 1 only.
- Wrap and stop:
  - Stimulus: 8 beats in PLAY, then stop.
  - Required: step_idx 0→7→0; after stop, step_idx 0, sequencer_on 0; pattern intact on next play (note_out 5 at step 0).
- Simultaneous events:
  - Stimulus (a): key_valid(9) and beat_pulse in the same REC cycle at step 2.
  - Required (a): pattern[2]=9, step_idx 3.
  - Stimulus (b): stop+play in the same cycle.
  - Required (b): STOP.
- Clear gating:
  - Stimulus: clear during PLAY, then clear in STOP.
  - Required: pattern unchanged after the first; all-zero after the second, so gate never rises on replay.
- Retrigger:
  - Stimulus: in REC with gate 2 cycles from expiry, key 7.
  - Required: gate stays continuously high, for a further 4 cycles; note_out 7.
